// File: rtl/reg_file_sb.sv
// reg_file_sb
// Register file for the pipelined MIPS datapath. It has two combinational read
// ports and one clocked write port. A per-register busy bit marks every
// register whose producer has issued but not yet written back, so decode can
// detect RAW hazards straight from the read addresses.
//
// Parameters
//   DATA_W    register width
//   ADDR_W    address width, depth = 2**ADDR_W
//   ZERO_REG  1: r0 reads as 0 and ignores writes and issues
//   BYPASS    1: a write in the current cycle is forwarded to matching read ports
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   RA1/RA2 -> DR1/DR2  read address -> read data (combinational)
//   WA, Din, RegWrite   write port; RegWrite also clears busy[WA]
//   IssueValid, IssueWA marks IssueWA busy (in-flight producer)
//   Flush               clears all busy bits; data is kept
//   Busy1/Busy2         RA1/RA2 has a pending producer
//   PendingCount        number of busy registers (registered)
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic [DATA_W-1:0] DR1,
   output logic [DATA_W-1:0] DR2,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] Din,
   input  logic              RegWrite,
   input  logic              IssueValid,
   input  logic [ADDR_W-1:0] IssueWA,
   input  logic              Flush,
   output logic              Busy1,
   output logic              Busy2,
   output logic [ADDR_W:0]   PendingCount
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [ADDR_W:0]   cnt_nxt;
   logic              wr_en;

   assign wr_en = RegWrite && !((ZERO_REG != 0) && (WA == '0));

   // Later assignments win: flush over issue over write-back clear. An issue
   // and a write-back to the same register in one cycle leave it busy because
   // the issuing instruction is the newer producer.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (RegWrite && (WA == ADDR_W'(i)))
            busy_nxt[i] = 1'b0;
         if (IssueValid && (IssueWA == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
            busy_nxt[i] = 1'b1;
         if (Flush)
            busy_nxt[i] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++)
         cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
   end

   // The count is registered from the next-state vector so that it changes on
   // the same edge as the busy bits it summarises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy         <= '0;
         PendingCount <= '0;
      end else begin
         if (wr_en)
            regs[WA] <= Din;
         busy         <= busy_nxt;
         PendingCount <= cnt_nxt;
      end
   end

   // The r0 override is applied last so that it also wins over the bypass.
   always_comb begin
      DR1   = regs[RA1];
      Busy1 = busy[RA1];
      if ((BYPASS != 0) && RegWrite && (WA == RA1)) begin
         DR1   = Din;
         Busy1 = 1'b0;
      end
      if ((ZERO_REG != 0) && (RA1 == '0)) begin
         DR1   = '0;
         Busy1 = 1'b0;
      end
   end

   always_comb begin
      DR2   = regs[RA2];
      Busy2 = busy[RA2];
      if ((BYPASS != 0) && RegWrite && (WA == RA2)) begin
         DR2   = Din;
         Busy2 = 1'b0;
      end
      if ((ZERO_REG != 0) && (RA2 == '0)) begin
         DR2   = '0;
         Busy2 = 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

   logic        clk_sys = 1'b0;
   logic        rst_n;
   logic [4:0]  ra1, ra2, wa, issue_wa;
   logic [31:0] din;
   logic        reg_write, issue_valid, flush;
   logic [31:0] dr1, dr2;
   logic        busy1, busy2;
   logic [5:0]  pending_count;

   int n_checks = 0;
   int n_pass   = 0;

   localparam int K_DR1 = 0, K_DR2 = 1, K_BUSY1 = 2, K_BUSY2 = 3, K_CNT = 4;

   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk_sys = ~clk_sys;

   reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk          (clk_sys),
      .rst_n        (rst_n),
      .RA1          (ra1),
      .RA2          (ra2),
      .DR1          (dr1),
      .DR2          (dr2),
      .WA           (wa),
      .Din          (din),
      .RegWrite     (reg_write),
      .IssueValid   (issue_valid),
      .IssueWA      (issue_wa),
      .Flush        (flush),
      .Busy1        (busy1),
      .Busy2        (busy2),
      .PendingCount (pending_count)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic push(input int kind, input logic [31:0] exp, input string tag);
      exp_t e;
      e.kind = kind;
      e.exp  = exp;
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                        input logic rw, input logic [4:0] w, input logic [31:0] d,
                        input logic iv, input logic [4:0] iw, input logic fl);
      ra1 = a1; ra2 = a2; reg_write = rw; wa = w; din = d;
      issue_valid = iv; issue_wa = iw; flush = fl;
   endtask

   // Settle the combinational outputs, then pop and compare every pending expectation.
   task automatic sample_and_drain();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            K_DR1:   obs = dr1;
            K_DR2:   obs = dr2;
            K_BUSY1: obs = {31'b0, busy1};
            K_BUSY2: obs = {31'b0, busy2};
            default: obs = {26'b0, pending_count};
         endcase
         check_val(e.tag, obs, e.exp);
      end
   endtask

   task automatic idle_cycle(input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk_sys);
      drive(a1, a2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk_sys);

      // Reset: every address reads zero on both ports, nothing busy.
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i);
         ra2 = 5'(31 - i);
         push(K_DR1, 32'd0, "rst_dr1");
         push(K_DR2, 32'd0, "rst_dr2");
         push(K_BUSY1, 32'd0, "rst_busy1");
         push(K_BUSY2, 32'd0, "rst_busy2");
         push(K_CNT, 32'd0, "rst_cnt");
         sample_and_drain();
      end
      @(negedge clk_sys);
      rst_n = 1'b1;

      // Bypassed write, then the stored value.
      @(negedge clk_sys);
      drive(5'd5, 5'd6, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
      push(K_DR1, 32'hDEADBEEF, "byp_dr1");
      push(K_DR2, 32'd0, "byp_dr2_other");
      sample_and_drain();
      idle_cycle(5'd5, 5'd5);
      push(K_DR1, 32'hDEADBEEF, "stored_dr1");
      push(K_DR2, 32'hDEADBEEF, "stored_dr2_same");
      sample_and_drain();

      // Zero register ignores writes and issues.
      @(negedge clk_sys);
      drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0);
      push(K_DR1, 32'd0, "r0_write_dr1");
      sample_and_drain();
      @(negedge clk_sys);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
      push(K_DR1, 32'd0, "r0_issue_dr1");
      push(K_BUSY1, 32'd0, "r0_issue_busy1");
      sample_and_drain();
      idle_cycle(5'd0, 5'd0);
      push(K_DR1, 32'd0, "r0_after_dr1");
      push(K_BUSY1, 32'd0, "r0_after_busy1");
      push(K_CNT, 32'd0, "r0_after_cnt");
      sample_and_drain();

      // Scoreboard lifecycle: issue 3, issue 7, write back 3.
      @(negedge clk_sys);
      drive(5'd3, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
      push(K_BUSY1, 32'd0, "iss3_busy1_same_cycle");
      push(K_CNT, 32'd0, "iss3_cnt_same_cycle");
      sample_and_drain();
      @(negedge clk_sys);
      drive(5'd3, 5'd7, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
      push(K_BUSY1, 32'd1, "iss7_busy1_r3");
      push(K_BUSY2, 32'd0, "iss7_busy2_r7");
      push(K_CNT, 32'd1, "iss7_cnt");
      sample_and_drain();
      @(negedge clk_sys);
      drive(5'd3, 5'd7, 1'b1, 5'd3, 32'h0000A5A5, 1'b0, 5'd0, 1'b0);
      push(K_BUSY1, 32'd0, "wb3_busy1_bypass");
      push(K_DR1, 32'h0000A5A5, "wb3_dr1_bypass");
      push(K_BUSY2, 32'd1, "wb3_busy2_r7");
      push(K_CNT, 32'd2, "wb3_cnt");
      sample_and_drain();
      idle_cycle(5'd3, 5'd7);
      push(K_BUSY1, 32'd0, "post_wb3_busy1");
      push(K_BUSY2, 32'd1, "post_wb3_busy2");
      push(K_CNT, 32'd1, "post_wb3_cnt");
      sample_and_drain();

      // Issue and write back to the same busy register in one cycle.
      @(negedge clk_sys);
      drive(5'd3, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
      sample_and_drain();
      @(negedge clk_sys);
      drive(5'd3, 5'd9, 1'b1, 5'd9, 32'h00000099, 1'b1, 5'd9, 1'b0);
      push(K_BUSY2, 32'd0, "same_busy2_bypass");
      push(K_CNT, 32'd2, "same_cnt_before");
      sample_and_drain();
      idle_cycle(5'd3, 5'd9);
      push(K_BUSY2, 32'd1, "same_busy2_after");
      push(K_CNT, 32'd2, "same_cnt_after");
      push(K_DR2, 32'h00000099, "same_dr2_after");
      sample_and_drain();

      // Busy on 2, 4, 6 (7 and 9 still busy), then flush with issue on 8 and a write to 10.
      for (int i = 2; i <= 6; i += 2) begin
         @(negedge clk_sys);
         drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b0);
      end
      idle_cycle(5'd4, 5'd6);
      push(K_CNT, 32'd5, "pre_flush_cnt");
      push(K_BUSY1, 32'd1, "pre_flush_busy1");
      sample_and_drain();
      @(negedge clk_sys);
      drive(5'd8, 5'd10, 1'b1, 5'd10, 32'h00001010, 1'b1, 5'd8, 1'b1);
      sample_and_drain();
      idle_cycle(5'd8, 5'd10);
      push(K_CNT, 32'd0, "flush_cnt");
      push(K_BUSY1, 32'd0, "flush_busy1_r8");
      push(K_DR2, 32'h00001010, "flush_write_kept");
      sample_and_drain();
      ra1 = 5'd5;
      ra2 = 5'd9;
      push(K_DR1, 32'hDEADBEEF, "flush_data_r5");
      push(K_DR2, 32'h00000099, "flush_data_r9");
      push(K_BUSY2, 32'd0, "flush_busy2_r9");
      sample_and_drain();

      // Async reset between edges.
      @(negedge clk_sys);
      drive(5'd5, 5'd12, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0);
      idle_cycle(5'd5, 5'd12);
      push(K_CNT, 32'd1, "pre_rst_cnt");
      push(K_BUSY2, 32'd1, "pre_rst_busy2");
      sample_and_drain();
      rst_n = 1'b0;
      push(K_DR1, 32'd0, "arst_dr1");
      push(K_BUSY2, 32'd0, "arst_busy2");
      push(K_CNT, 32'd0, "arst_cnt");
      sample_and_drain();
      ra2 = 5'd10;
      push(K_DR2, 32'd0, "arst_dr2");
      sample_and_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
